// File: rtl/avg_pkg.sv
// Shared types and constants for the AVG per-frame sequencer.
package avg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LAUNCH,
        RUN,
        DRAIN,
        SWAP
    } avg_frame_state_t;

    // Default watchdog budget (cycles in RUN before the frame is aborted).
    localparam int AVG_TIMEOUT_DEF = 1_000_000;

endpackage

// File: rtl/avg_watchdog.sv
// Loadable down-counter used as the RUN-state watchdog.
// expired_o fires on the decrement that takes the count to zero, so a load of N
// allows exactly N decrement cycles. The count holds at zero.
module avg_watchdog
    import avg_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = AVG_TIMEOUT_DEF,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk_i,
    input  logic rst_b_i,
    input  logic load_i,
    input  logic dec_i,
    output logic expired_o
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: load wins over decrement, never wrap below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = LOAD_VAL;
        else if (dec_i && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_b_i) begin
        if (!rst_b_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign expired_o = dec_i && (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/avg_frame_ctrl.sv
// Per-frame sequencer for the AVG vector pipeline:
// clear back buffer -> launch avg_core -> drain line queue -> swap buffers.
// Optional build macro AVG_FRAME_STATS_EN adds per-frame line/cycle statistics.
module avg_frame_ctrl
    import avg_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = AVG_TIMEOUT_DEF,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        frameTick,
    output logic        clearStart,
    input  logic        clearDone,
    output logic        vggo,
    input  logic        avgHalted,
    output logic        avgRun,
    input  logic        queueFull,
    input  logic        queueEmpty,
    output logic        queueRead,
    output logic        lineValid,
    input  logic        lineReady,
    input  logic        drawerIdle,
    output logic        fbSwap,
    output logic        busy,
    output logic        frameOverrun,
    output logic        timeoutFlag
`ifdef AVG_FRAME_STATS_EN
    ,
    output logic [15:0] statLines,
    output logic [23:0] statCycles
`endif
);

    avg_frame_state_t state_q, state_d;

    logic pending_q, pending_d;
    logic clearStart_q, clearStart_d;
    logic vggo_q, vggo_d;
    logic fbSwap_q, fbSwap_d;
    logic overrun_q, overrun_d;
    logic timeout_q, timeout_d;

    logic clear_go;    // IDLE -> CLEAR this cycle
    logic halt_seen;   // halt flag trusted (not the stale value from before vggo)
    logic wd_load, wd_dec, wd_expired;

    assign busy      = (state_q != IDLE);
    assign clear_go  = (state_q == IDLE) && (frameTick || pending_q);
    // vggo_q is high exactly in the first RUN cycle, when the core halt reg is still stale.
    assign halt_seen = avgHalted && !vggo_q;
    assign wd_load   = (state_q == LAUNCH);
    assign wd_dec    = (state_q == RUN);

    avg_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_wd (
        .clk_i    (clk),
        .rst_b_i  (rst_b),
        .load_i   (wd_load),
        .dec_i    (wd_dec),
        .expired_o(wd_expired)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; halt takes priority over watchdog expiry in RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (clear_go)                              state_d = CLEAR;
            CLEAR:   if (clearDone)                             state_d = LAUNCH;
            LAUNCH:                                             state_d = RUN;
            RUN:     if (halt_seen || wd_expired)               state_d = DRAIN;
            DRAIN:   if (queueEmpty && drawerIdle && !lineValid) state_d = SWAP;
            SWAP:                                               state_d = IDLE;
            default:                                            state_d = IDLE;
        endcase
    end

    // Outputs: combinational handshake/stall, next values for registered pulses and flags.
    always_comb begin
        avgRun       = (state_q == RUN) && !queueFull;
        lineValid    = ((state_q == RUN) || (state_q == DRAIN)) && !queueEmpty;
        queueRead    = lineValid && lineReady;
        clearStart_d = clear_go;
        vggo_d       = (state_q == LAUNCH);
        fbSwap_d     = (state_q == SWAP);
        overrun_d    = busy && frameTick;
        pending_d    = pending_q;
        if (busy && frameTick) pending_d = 1'b1;
        else if (clear_go)     pending_d = 1'b0;
        timeout_d    = timeout_q;
        if (clear_go)
            timeout_d = 1'b0;
        else if ((state_q == RUN) && wd_expired && !halt_seen)
            timeout_d = 1'b1;
    end

    // Registered pulse outputs and sticky flags.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            pending_q    <= 1'b0;
            clearStart_q <= 1'b0;
            vggo_q       <= 1'b0;
            fbSwap_q     <= 1'b0;
            overrun_q    <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            clearStart_q <= clearStart_d;
            vggo_q       <= vggo_d;
            fbSwap_q     <= fbSwap_d;
            overrun_q    <= overrun_d;
            timeout_q    <= timeout_d;
        end
    end

    assign clearStart   = clearStart_q;
    assign vggo         = vggo_q;
    assign fbSwap       = fbSwap_q;
    assign frameOverrun = overrun_q;
    assign timeoutFlag  = timeout_q;

`ifdef AVG_FRAME_STATS_EN
    logic [15:0] lines_q, lines_d, statLines_q;
    logic [23:0] cyc_q, cyc_d, statCycles_q;

    // Running per-frame counters, restarted on CLEAR entry, saturating.
    always_comb begin
        lines_d = lines_q;
        cyc_d   = cyc_q;
        if (clear_go) begin
            lines_d = '0;
            cyc_d   = '0;
        end else if (busy) begin
            if (queueRead && lines_q != '1) lines_d = lines_q + 1'b1;
            if (cyc_q != '1)                cyc_d   = cyc_q + 1'b1;
        end
    end

    // Counter registers; results latched in SWAP (count includes the SWAP cycle).
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            lines_q      <= '0;
            cyc_q        <= '0;
            statLines_q  <= '0;
            statCycles_q <= '0;
        end else begin
            lines_q <= lines_d;
            cyc_q   <= cyc_d;
            if (state_q == SWAP) begin
                statLines_q  <= lines_d;
                statCycles_q <= cyc_d;
            end
        end
    end

    assign statLines  = statLines_q;
    assign statCycles = statCycles_q;
`endif

endmodule

// File: tb/tb_avg_frame_ctrl.sv
// Directed bench for avg_frame_ctrl (watchdog shortened to 100 cycles).
module tb_avg_frame_ctrl;

    localparam int TO = 100;

    logic clk = 1'b0;
    logic rst_b, frameTick, clearDone, avgHalted, queueFull, lineReady, drawerIdle;
    logic queueEmpty;
    logic clearStart, vggo, avgRun, queueRead, lineValid, fbSwap, busy, frameOverrun, timeoutFlag;

    always #5 clk = ~clk;

    avg_frame_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .frameTick   (frameTick),
        .clearStart  (clearStart),
        .clearDone   (clearDone),
        .vggo        (vggo),
        .avgHalted   (avgHalted),
        .avgRun      (avgRun),
        .queueFull   (queueFull),
        .queueEmpty  (queueEmpty),
        .queueRead   (queueRead),
        .lineValid   (lineValid),
        .lineReady   (lineReady),
        .drawerIdle  (drawerIdle),
        .fbSwap      (fbSwap),
        .busy        (busy),
        .frameOverrun(frameOverrun),
        .timeoutFlag (timeoutFlag)
    );

    // Line queue model: loadable occupancy, popped by queueRead.
    int   qcnt = 0;
    logic q_set_en = 1'b0;
    int   q_set_val = 0;
    always @(posedge clk) begin
        if (q_set_en)                  qcnt <= q_set_val;
        else if (queueRead && qcnt > 0) qcnt <= qcnt - 1;
    end
    assign queueEmpty = (qcnt == 0);

    // Event counters sampled on the falling edge.
    localparam int C_CLR = 0, C_GO = 1, C_POP = 2, C_SWAP = 3, C_OVR = 4,
                   C_RUN = 5, C_STALL = 6, C_BADPOP = 7, C_BADRUN = 8;
    int cnt [9];
    int base [9];
    always @(negedge clk) begin
        if (rst_b) begin
            cnt[C_CLR]    <= cnt[C_CLR]    + int'(clearStart);
            cnt[C_GO]     <= cnt[C_GO]     + int'(vggo);
            cnt[C_POP]    <= cnt[C_POP]    + int'(queueRead);
            cnt[C_SWAP]   <= cnt[C_SWAP]   + int'(fbSwap);
            cnt[C_OVR]    <= cnt[C_OVR]    + int'(frameOverrun);
            cnt[C_RUN]    <= cnt[C_RUN]    + int'(avgRun);
            cnt[C_STALL]  <= cnt[C_STALL]  + int'(busy & queueFull & ~avgRun);
            cnt[C_BADPOP] <= cnt[C_BADPOP] + int'(queueRead & queueEmpty);
            cnt[C_BADRUN] <= cnt[C_BADRUN] + int'(avgRun & queueFull);
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int d(input int i);
        return cnt[i] - base[i];
    endfunction

    task automatic snap();
        for (int i = 0; i < 9; i++) base[i] = cnt[i];
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_vggo(input int limit);
        int k;
        k = 0;
        while (k < limit && vggo !== 1'b1) begin
            @(negedge clk);
            k++;
        end
        chk("vggo_seen", 32'(vggo), 1);
    endtask

    task automatic wait_idle(input int limit);
        int k;
        k = 0;
        while (k < limit && busy !== 1'b0) begin
            @(negedge clk);
            k++;
        end
        chk("idle_reached", 32'(busy), 0);
    endtask

    task automatic load_q(input int n);
        q_set_en = 1'b1; q_set_val = n;
        cyc(1);
        q_set_en = 1'b0;
    endtask

    // Tick, hold clear for clr_wait cycles, launch; returns in the 2nd RUN cycle with halt dropped.
    task automatic start_frame(input int clr_wait);
        frameTick = 1'b1;
        cyc(1);
        frameTick = 1'b0;
        chk("clearStart_pulse", 32'(clearStart), 1);
        chk("timeout_cleared_on_clear", 32'(timeoutFlag), 0);
        cyc(clr_wait - 1);
        clearDone = 1'b1;
        cyc(1);
        clearDone = 1'b0;
        wait_vggo(20);
        @(posedge clk); #1;
        avgHalted = 1'b0;
    endtask

    function automatic logic [31:0] outs();
        return 32'({clearStart, vggo, avgRun, queueRead, lineValid,
                    fbSwap, busy, frameOverrun, timeoutFlag});
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_b = 1'b1; frameTick = 1'b0; clearDone = 1'b0; avgHalted = 1'b1;
        queueFull = 1'b0; lineReady = 1'b1; drawerIdle = 1'b1;
        #3 rst_b = 1'b0;
        #9;
        chk("reset_outputs", outs(), 0);
        cyc(1);
        rst_b = 1'b1;
        cyc(2);
        chk("idle_outputs", outs(), 0);

        // 1: normal frame, 5 lines, halt 50 cycles after vggo
        snap();
        start_frame(10);
        load_q(5);
        chk("lineValid_run", 32'(lineValid), 1);
        cyc(48);
        avgHalted = 1'b1;
        wait_idle(100);
        cyc(2);
        chk("t1_clearStart", d(C_CLR), 1);
        chk("t1_vggo", d(C_GO), 1);
        chk("t1_pops", d(C_POP), 5);
        chk("t1_fbSwap", d(C_SWAP), 1);
        chk("t1_run_cycles", d(C_RUN), 51);
        chk("t1_overrun", d(C_OVR), 0);
        chk("t1_timeoutFlag", 32'(timeoutFlag), 0);

        // 2: backpressure 20 cycles, empty queue, drawer busy delays SWAP
        snap();
        start_frame(3);
        queueFull = 1'b1;
        cyc(20);
        queueFull = 1'b0;
        cyc(28);
        avgHalted = 1'b1; drawerIdle = 1'b0;
        cyc(5);
        chk("t2_wait_drawer", 32'(busy), 1);
        chk("t2_drain_avgRun", 32'(avgRun), 0);
        drawerIdle = 1'b1;
        wait_idle(20);
        cyc(2);
        chk("t2_stall_cycles", d(C_STALL), 20);
        chk("t2_run_cycles", d(C_RUN), 30);
        chk("t2_run_while_full", d(C_BADRUN), 0);
        chk("t2_pops", d(C_POP), 0);
        chk("t2_fbSwap", d(C_SWAP), 1);

        // 3: watchdog, halt never rises
        snap();
        start_frame(2);
        wait_idle(200);
        cyc(2);
        chk("t3_run_cycles", d(C_RUN), TO);
        chk("t3_timeoutFlag", 32'(timeoutFlag), 1);
        chk("t3_fbSwap", d(C_SWAP), 1);

        // 4: two ticks in RUN -> two overruns, exactly one extra frame
        snap();
        start_frame(2);
        cyc(3);
        frameTick = 1'b1;
        cyc(1);
        frameTick = 1'b0;
        chk("t4_overrun_pulse", 32'(frameOverrun), 1);
        cyc(3);
        frameTick = 1'b1;
        cyc(1);
        frameTick = 1'b0;
        cyc(2);
        clearDone = 1'b1; avgHalted = 1'b1;
        wait_vggo(30);
        @(posedge clk); #1;
        avgHalted = 1'b0; clearDone = 1'b0;
        cyc(5);
        avgHalted = 1'b1;
        wait_idle(30);
        cyc(8);
        chk("t4_overruns", d(C_OVR), 2);
        chk("t4_clearStarts", d(C_CLR), 2);
        chk("t4_vggos", d(C_GO), 2);
        chk("t4_fbSwaps", d(C_SWAP), 2);
        chk("t4_idle_after", 32'(busy), 0);

        // 5: stale halt in first RUN cycle only
        start_frame(1);
        cyc(10);
        chk("t5_still_running", 32'(avgRun), 1);
        avgHalted = 1'b1;
        cyc(1);
        chk("t5_drain_on_halt", 32'(avgRun), 0);
        wait_idle(20);

        // 6: async reset in DRAIN with lines queued
        snap();
        start_frame(2);
        lineReady = 1'b0;
        load_q(3);
        chk("t6_lineValid", 32'(lineValid), 1);
        avgHalted = 1'b1;
        cyc(4);
        chk("t6_in_drain", {30'd0, busy, lineValid}, 3);
        #2 rst_b = 1'b0;
        #1;
        chk("t6_reset_outputs", outs(), 0);
        cyc(1);
        load_q(0);
        lineReady = 1'b1;
        rst_b = 1'b1;
        cyc(2);
        chk("t6_pops", d(C_POP), 0);
        chk("t6_idle_after_reset", outs(), 0);
        chk("no_pop_when_empty", cnt[C_BADPOP], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
